// File: rtl/mem_lsu_master.sv
// Load/store requester for the word-addressed data memory: sub-word stores run as read-modify-write.
// Optional misalignment rejection is enabled by defining LSU_ALIGN_CHECK_EN.
module mem_lsu_master #(
  parameter int MEM_AW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]        state;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        lane;
  logic [MEM_AW-1:0] idx;
  logic [31:0]       wbuf;

  logic [1:0]  req_sz;
  logic [1:0]  req_lane;
  logic        req_misaligned;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:MEM_AW+2];

  // Size 11 behaves as a word; the lane drops address bits below the access size.
  always_comb begin
    req_sz   = (req_size == 2'b11) ? 2'b10 : req_size;
    req_lane = req_addr[1:0];
    case (req_sz)
      2'b00:   req_lane = req_addr[1:0];
      2'b01:   req_lane = {req_addr[1], 1'b0};
      default: req_lane = 2'b00;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign req_misaligned = (req_sz == 2'b01) ? req_addr[0] :
                          (req_sz == 2'b10) ? (|req_addr[1:0]) : 1'b0;
`else
  assign req_misaligned = 1'b0;
`endif

  always_comb begin
    rd_byte = mem_rd[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (size_q)
      2'b00:   load_val = {{24{signed_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{signed_q & rd_half[15]}}, rd_half};
      default: load_val = mem_rd;
    endcase
    merged = mem_rd;
    if (size_q == 2'b00)
      merged[{lane, 3'b000} +: 8] = wbuf[7:0];
    else
      merged[{lane[1], 4'b0000} +: 16] = wbuf[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      lane      <= 2'b00;
      idx       <= '0;
      wbuf      <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            size_q   <= req_sz;
            signed_q <= req_signed;
            lane     <= req_lane;
            idx      <= req_addr[MEM_AW+1:2];
            wbuf     <= req_wdata;
            if (req_misaligned) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
              state     <= S_RESP;
            end else if (!req_we) begin
              state <= S_LOAD;
            end else if (req_sz == 2'b10) begin
              state <= S_WRITE;
            end else begin
              state <= S_RMW_RD;
            end
          end
        end
        S_LOAD: begin
          rsp_rdata <= load_val;
          rsp_err   <= 1'b0;
          state     <= S_RESP;
        end
        S_RMW_RD: begin
          wbuf  <= merged;
          state <= S_WRITE;
        end
        S_WRITE: begin
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
          state     <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write enable is gated by reset so a reset landing in WRITE never touches memory.
  assign mem_we    = (state == S_WRITE) & rst_n;
  assign mem_wd    = (state == S_WRITE) ? wbuf : 32'd0;
  assign mem_a     = {{(32-MEM_AW){1'b0}}, idx};
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

endmodule

// File: tb/tb_mem_lsu_master.sv
// Scoreboard bench for mem_lsu_master: a byte-arithmetic memory model predicts responses and accesses.
module tb_mem_lsu_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] idx;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  acc_t        acc_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];
  int          cyc;
  int          tests;
  int          failed;

  mem_lsu_master #(.MEM_AW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment memory: asynchronous read, write on the edge closing a mem_we cycle.
  assign mem_rd = tb_mem[mem_a[7:0]];
  always @(posedge clk) if (mem_we) tb_mem[mem_a[7:0]] <= mem_wd;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares memory accesses and responses against the queued predictions.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
        check_output("missed_access", 32'd0, acc_q[0].idx);
        void'(acc_q.pop_front());
      end
      if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
        acc_t e;
        e = acc_q.pop_front();
        check_output("mem_we", {31'd0, mem_we}, {31'd0, e.we});
        check_output("mem_a", mem_a, e.idx);
        if (e.we) check_output("mem_wd", mem_wd, e.data);
      end else if (mem_we) begin
        check_output("unexpected_write", {31'd0, mem_we}, 32'd0);
      end
      if (!mem_we) check_output("mem_wd_idle", mem_wd, 32'd0);

      while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
        check_output("missed_rsp", 32'd0, 32'd1);
        void'(rsp_q.pop_front());
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check_output("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check_output("rsp_cycle", cyc, r.cyc);
          check_output("rsp_rdata", rsp_rdata, r.rdata);
          check_output("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
        end
      end
    end
  end

  // Called at posedge+#1. Waits for req_ready (presenting ignored junk meanwhile), issues one
  // request, and predicts its accesses and response from byte-lane arithmetic on ref_mem.
  task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata);
    int          waits;
    int          nb;
    int          lo;
    int          a;
    logic [31:0] idx;
    logic        err;
    logic [63:0] lmask;
    logic [63:0] word;
    logic [63:0] val;
    logic [63:0] nw;
    waits = 0;
    while (req_ready !== 1'b1) begin
      if (waits > 20) begin
        check_output("ready_timeout", {31'd0, req_ready}, 32'd1);
        return;
      end
      req_valid  = 1'($urandom_range(0, 1));
      req_we     = 1'($urandom_range(0, 1));
      req_size   = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      @(posedge clk);
      #1;
      waits++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    a = cyc;

    nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    idx = {24'd0, addr[9:2]};
    lo  = int'(addr[1:0]);
`ifdef LSU_ALIGN_CHECK_EN
    err = (lo % nb) != 0;
`else
    err = 1'b0;
    lo  = lo - (lo % nb);
`endif
    lmask = (64'd1 << (8 * nb)) - 64'd1;
    word  = {32'd0, ref_mem[idx[7:0]]};
    if (err) begin
      rsp_q.push_back('{a + 1, 32'd0, 1'b1});
    end else if (!we) begin
      val = (word >> (8 * lo)) & lmask;
      if (sgn && nb < 4 && val[8 * nb - 1]) val = val | ~lmask;
      acc_q.push_back('{a + 1, 1'b0, idx, 32'd0});
      rsp_q.push_back('{a + 2, val[31:0], 1'b0});
    end else begin
      nw = (word & ~(lmask << (8 * lo))) | (({32'd0, wdata} & lmask) << (8 * lo));
      if (nb == 4) begin
        acc_q.push_back('{a + 1, 1'b1, idx, nw[31:0]});
        rsp_q.push_back('{a + 2, 32'd0, 1'b0});
      end else begin
        acc_q.push_back('{a + 1, 1'b0, idx, 32'd0});
        acc_q.push_back('{a + 2, 1'b1, idx, nw[31:0]});
        rsp_q.push_back('{a + 3, 32'd0, 1'b0});
      end
      ref_mem[idx[7:0]] = nw[31:0];
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          n;
    int          nmis;
    logic [31:0] addr;
    tests      = 0;
    failed     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check_output("reset_mem_we", {31'd0, mem_we}, 32'd0);
    check_output("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_output("reset_mem_a", mem_a, 32'd0);
    check_output("reset_mem_wd", mem_wd, 32'd0);
    check_output("reset_rsp_rdata", rsp_rdata, 32'd0);
    check_output("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    apply_stimulus(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5);
    apply_stimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    apply_stimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    apply_stimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001);
    apply_stimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h412, 32'h0);
    apply_stimulus(1'b0, 2'b11, 1'b0, 32'h14, 32'h0);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    apply_stimulus(1'b1, 2'b01, 1'b0, 32'h23, 32'h0000BEEF);
    wait_idle();
    check_output("word4_after_half_store", tb_mem[4], 32'h80013344);

    // Reset asserted during the WRITE cycle of a byte store must abandon it silently.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h13;
    req_wdata = 32'h0000005A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("rst_write_mem_we", {31'd0, mem_we}, 32'd0);
    check_output("rst_write_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_output("rst_write_ready", {31'd0, req_ready}, 32'd1);
    check_output("rst_write_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check_output("rst_write_mem_kept", tb_mem[4], 32'h80013344);
    apply_stimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);

    for (int i = 0; i < 200; i++) begin
      addr = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      apply_stimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), addr, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    n = 0;
    while ((rsp_q.size() != 0 || acc_q.size() != 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("drain_rsp_q", 32'(rsp_q.size()), 32'd0);
    check_output("drain_acc_q", 32'(acc_q.size()), 32'd0);
    @(posedge clk);
    #1;
    nmis = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) nmis++;
    check_output("mem_final_mismatches", 32'(nmis), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
